// File: rtl/sudoku_ctrl.sv
// sudoku_ctrl: game sequencer for the 4x4 Sudoku datapath.
// It generates the board seed, strobes the datapath through each game phase,
// tracks hint-locked and user-filled cells, and counts failed checks.
module sudoku_ctrl #(
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter int unsigned MAX_TRIES  = 3,
    parameter int unsigned CHECK_WAIT = 2
) (
    input  logic        clka,
    input  logic        restart_n,
    input  logic        start,
    input  logic        enter,
    input  logic        submit,
    input  logic [1:0]  diff_sel,
    input  logic [3:0]  cell_in,
    input  logic [2:0]  value_in,
    input  logic        solved,
    output logic        dp_restart,
    output logic        set_board,
    output logic [1:0]  difficulty,
    output logic        register_inp_flag,
    output logic [3:0]  reg_choose,
    output logic [2:0]  value_inp,
    output logic        dp_check,
    output logic        try_again_flag,
    output logic        won,
    output logic        lost,
    output logic [3:0]  ridx_a,
    output logic [3:0]  ridx_b,
    output logic [15:0] fill_flag,
    output logic [3:0]  state
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned CNT_W = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLEAR = 4'd1,
        S_BOARD = 4'd2,
        S_HINT  = 4'd3,
        S_PLAY  = 4'd4,
        S_WRITE = 4'd5,
        S_CHECK = 4'd6,
        S_JUDGE = 4'd7,
        S_TRY   = 4'd8,
        S_WON   = 4'd9,
        S_LOST  = 4'd10
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;
    logic [7:0]         lfsr;
    logic               lfsr_fb;
    logic [15:0]        user_mask;
    logic [TRY_W-1:0]   tries;
    logic [TRY_W-1:0]   tries_inc;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         diff_lat;
    logic               start_ok;
    logic               enter_ok;
    logic               submit_ok;
    logic [15:0]        hint_mask;
    logic [1:0]         r0, r1, r2, r3;

    assign state = cur_state;

    // Request qualification and LFSR feedback
    always_comb begin
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        start_ok  = start && (cur_state != S_CLEAR) && (cur_state != S_BOARD)
                          && (cur_state != S_HINT);
        enter_ok  = enter && !value_in[2] && !fill_flag[cell_in];
        submit_ok = submit && ((fill_flag | user_mask) == 16'hFFFF);
        tries_inc = tries + TRY_W'(1);
    end

    // Hint-locked cell mask from the captured seed indices and difficulty
    always_comb begin
        r0        = ridx_a[1:0];
        r1        = ridx_a[3:2];
        r2        = ridx_b[1:0];
        r3        = ridx_b[3:2];
        hint_mask = 16'h0000;
        hint_mask[{2'd0, r0}] = 1'b1;
        hint_mask[{2'd3, r3}] = 1'b1;
        if (diff_lat == 2'b01) begin
            if (r1 == 2'd0 || r1 == 2'd3) begin
                hint_mask[4] = 1'b1;
                hint_mask[7] = 1'b1;
            end else begin
                hint_mask[5] = 1'b1;
                hint_mask[6] = 1'b1;
            end
        end else begin
            hint_mask[{2'd1, r1}] = 1'b1;
        end
        if (diff_lat == 2'b11) begin
            hint_mask[{2'd2, r2}] = 1'b1;
        end else if (r2 == 2'd0 || r2 == 2'd3) begin
            hint_mask[8]  = 1'b1;
            hint_mask[11] = 1'b1;
        end else begin
            hint_mask[9]  = 1'b1;
            hint_mask[10] = 1'b1;
        end
    end

    // Next-state selection; start overrides everything outside the setup phase
    always_comb begin
        nxt_state = cur_state;
        if (start_ok) begin
            nxt_state = S_CLEAR;
        end else begin
            case (cur_state)
                S_IDLE:  nxt_state = S_IDLE;
                S_CLEAR: nxt_state = S_BOARD;
                S_BOARD: nxt_state = S_HINT;
                S_HINT:  nxt_state = S_PLAY;
                S_PLAY: begin
                    if (enter_ok) begin
                        nxt_state = S_WRITE;
                    end else if (submit_ok) begin
                        nxt_state = S_CHECK;
                    end
                end
                S_WRITE: nxt_state = S_PLAY;
                S_CHECK: begin
                    if (wait_cnt == CNT_W'(0)) begin
                        nxt_state = S_JUDGE;
                    end
                end
                S_JUDGE: begin
                    if (solved) begin
                        nxt_state = S_WON;
                    end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
                        nxt_state = S_LOST;
                    end else begin
                        nxt_state = S_TRY;
                    end
                end
                S_TRY:   nxt_state = S_PLAY;
                S_WON:   nxt_state = S_WON;
                S_LOST:  nxt_state = S_LOST;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // State, game bookkeeping and registered outputs decoded from the next state
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            cur_state         <= S_IDLE;
            lfsr              <= LFSR_SEED;
            user_mask         <= 16'h0000;
            tries             <= '0;
            wait_cnt          <= '0;
            diff_lat          <= 2'b00;
            dp_restart        <= 1'b0;
            set_board         <= 1'b0;
            difficulty        <= 2'b00;
            register_inp_flag <= 1'b0;
            reg_choose        <= 4'h0;
            value_inp         <= 3'd0;
            dp_check          <= 1'b0;
            try_again_flag    <= 1'b0;
            won               <= 1'b0;
            lost              <= 1'b0;
            ridx_a            <= 4'h0;
            ridx_b            <= 4'h0;
            fill_flag         <= 16'h0000;
        end else begin
            lfsr              <= {lfsr[6:0], lfsr_fb};
            cur_state         <= nxt_state;
            dp_restart        <= (nxt_state == S_CLEAR);
            set_board         <= (nxt_state == S_BOARD);
            difficulty        <= (nxt_state == S_HINT) ? diff_lat : 2'b00;
            register_inp_flag <= (nxt_state == S_WRITE);
            dp_check          <= (nxt_state == S_CHECK);
            try_again_flag    <= (nxt_state == S_TRY);
            won               <= (nxt_state == S_WON);
            lost              <= (nxt_state == S_LOST);

            if (nxt_state == S_HINT) begin
                fill_flag <= hint_mask;
            end
            if (nxt_state == S_WRITE) begin
                reg_choose           <= cell_in;
                value_inp            <= value_in;
                user_mask[cell_in]   <= 1'b1;
            end
            if (nxt_state == S_CHECK && cur_state != S_CHECK) begin
                wait_cnt <= CNT_W'(CHECK_WAIT - 1);
            end else if (cur_state == S_CHECK && wait_cnt != CNT_W'(0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (nxt_state == S_TRY || nxt_state == S_LOST) begin
                tries <= tries_inc;
            end
            if (start_ok) begin
                ridx_a    <= lfsr[3:0];
                ridx_b    <= lfsr[7:4];
                diff_lat  <= (diff_sel == 2'b00) ? 2'b01 : diff_sel;
                user_mask <= 16'h0000;
                fill_flag <= 16'h0000;
                tries     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_ctrl.sv
// tb_sudoku_ctrl: directed and randomized checks of sudoku_ctrl against a
// game-level reference model (scheduled phase queue, cell-list hint rules).
module tb_sudoku_ctrl;

    localparam int CW = 2;
    localparam int MT = 3;

    logic        clka = 1'b0;
    logic        restart_n;
    logic        start, enter, submit, solved;
    logic [1:0]  diff_sel;
    logic [3:0]  cell_in;
    logic [2:0]  value_in;
    logic        dp_restart, set_board, register_inp_flag, dp_check;
    logic        try_again_flag, won, lost;
    logic [1:0]  difficulty;
    logic [3:0]  reg_choose, ridx_a, ridx_b, state;
    logic [2:0]  value_inp;
    logic [15:0] fill_flag;

    int total = 0;
    int bad   = 0;

    // Reference model of the game
    int          m_st;
    int          m_q[$];
    logic [7:0]  m_lfsr;
    logic [3:0]  m_ra, m_rb, m_cell;
    logic [2:0]  m_val;
    int          m_diff;
    logic [15:0] m_fill, m_user;
    int          m_tries;

    sudoku_ctrl #(.LFSR_SEED(8'hA5), .MAX_TRIES(MT), .CHECK_WAIT(CW)) dut (
        .clka(clka), .restart_n(restart_n), .start(start), .enter(enter),
        .submit(submit), .diff_sel(diff_sel), .cell_in(cell_in),
        .value_in(value_in), .solved(solved), .dp_restart(dp_restart),
        .set_board(set_board), .difficulty(difficulty),
        .register_inp_flag(register_inp_flag), .reg_choose(reg_choose),
        .value_inp(value_inp), .dp_check(dp_check),
        .try_again_flag(try_again_flag), .won(won), .lost(lost),
        .ridx_a(ridx_a), .ridx_b(ridx_b), .fill_flag(fill_flag), .state(state)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hint_of(input logic [3:0] ra, input logic [3:0] rb, input int d);
        int r0 = int'(ra[1:0]);
        int r1 = int'(ra[3:2]);
        int r2 = int'(rb[1:0]);
        int r3 = int'(rb[3:2]);
        logic [15:0] m = 16'h0;
        m[r0] = 1'b1;
        m[12 + r3] = 1'b1;
        if (d == 3) begin
            m[4 + r1] = 1'b1;
            m[8 + r2] = 1'b1;
        end else begin
            if (r2 == 0 || r2 == 3) begin m[8] = 1'b1; m[11] = 1'b1; end
            else begin m[9] = 1'b1; m[10] = 1'b1; end
            if (d == 1) begin
                if (r1 == 0 || r1 == 3) begin m[4] = 1'b1; m[7] = 1'b1; end
                else begin m[5] = 1'b1; m[6] = 1'b1; end
            end else begin
                m[4 + r1] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic bit m_enter_legal();
        return (value_in < 3'd4) && !m_fill[cell_in];
    endfunction

    task automatic model_reset();
        m_st = 0; m_q.delete(); m_lfsr = 8'hA5; m_ra = 0; m_rb = 0;
        m_cell = 0; m_val = 0; m_diff = 0; m_fill = 0; m_user = 0; m_tries = 0;
    endtask

    // One clock edge of the game, using the inputs the DUT sees on that edge
    task automatic model_step();
        if (!restart_n) begin
            model_reset();
        end else begin
            if (start && !(m_st >= 1 && m_st <= 3)) begin
                m_ra = m_lfsr[3:0]; m_rb = m_lfsr[7:4];
                m_diff = (diff_sel == 2'b00) ? 1 : int'(diff_sel);
                m_fill = 0; m_user = 0; m_tries = 0;
                m_st = 1; m_q = '{2, 3, 4};
            end else if (m_q.size() > 0) begin
                m_st = m_q.pop_front();
                if (m_st == 3) m_fill = hint_of(m_ra, m_rb, m_diff);
            end else if (m_st == 4) begin
                if (enter && m_enter_legal()) begin
                    m_cell = cell_in; m_val = value_in; m_user[cell_in] = 1'b1;
                    m_st = 5; m_q.push_back(4);
                end else if (submit && ((m_fill | m_user) == 16'hFFFF)) begin
                    m_st = 6;
                    for (int i = 1; i < CW; i++) m_q.push_back(6);
                    m_q.push_back(7);
                end
            end else if (m_st == 7) begin
                if (solved) m_st = 9;
                else begin
                    m_tries++;
                    if (m_tries == MT) m_st = 10;
                    else begin m_st = 8; m_q.push_back(4); end
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic compare_all();
        chk("state", state, m_st);
        chk("dp_restart", dp_restart, m_st == 1);
        chk("set_board", set_board, m_st == 2);
        chk("difficulty", difficulty, (m_st == 3) ? m_diff : 0);
        chk("register_inp_flag", register_inp_flag, m_st == 5);
        chk("reg_choose", reg_choose, m_cell);
        chk("value_inp", value_inp, m_val);
        chk("dp_check", dp_check, m_st == 6);
        chk("try_again_flag", try_again_flag, m_st == 8);
        chk("won", won, m_st == 9);
        chk("lost", lost, m_st == 10);
        chk("ridx_a", ridx_a, m_ra);
        chk("ridx_b", ridx_b, m_rb);
        chk("fill_flag", fill_flag, m_fill);
    endtask

    task automatic tick();
        @(posedge clka);
        model_step();
        @(negedge clka);
        compare_all();
    endtask

    task automatic do_reset();
        restart_n = 1'b0;
        #1;
        model_reset();
        chk("reset_state", state, 0);
        chk("reset_fill", fill_flag, 0);
        tick();
        restart_n = 1'b1;
    endtask

    task automatic start_game(input logic [1:0] d);
        start = 1'b1; diff_sel = d;
        tick();
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic enter_cell(input int c, input int v);
        enter = 1'b1; cell_in = 4'(c); value_in = 3'(v);
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic fill_free();
        for (int c = 0; c < 16; c++)
            if (!(m_fill[c] | m_user[c])) enter_cell(c, int'($urandom_range(0, 3)));
    endtask

    task automatic submit_run(input logic sv);
        submit = 1'b1; solved = sv;
        tick();
        submit = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        restart_n = 1'b0; start = 1'b0; enter = 1'b0; submit = 1'b0; solved = 1'b0;
        diff_sel = 2'b00; cell_in = 4'h0; value_in = 3'd0;
        model_reset();
        @(negedge clka);
        compare_all();
        tick();

        // First game: start on the first edge after reset release
        restart_n = 1'b1; start = 1'b1; diff_sel = 2'b11;
        tick();
        start = 1'b0;
        chk("lit_clear_state", state, 1);
        chk("lit_dp_restart", dp_restart, 1);
        chk("lit_ridx_a", ridx_a, 4'h5);
        chk("lit_ridx_b", ridx_b, 4'hA);
        tick();
        chk("lit_set_board", set_board, 1);
        tick();
        chk("lit_difficulty", difficulty, 2'b11);
        chk("lit_fill_11", fill_flag, 16'h4422);
        tick();
        chk("lit_play_state", state, 4);

        do_reset();
        start_game(2'b10);
        chk("lit_fill_10", fill_flag, 16'h4622);
        do_reset();
        start_game(2'b00);
        chk("lit_fill_00", fill_flag, 16'h4662);

        // Enter qualification
        enter_cell(1, 0);
        chk("lit_locked_ignored", state, 4);
        enter = 1'b1; cell_in = 4'd3; value_in = 3'd5;
        tick();
        enter = 1'b0;
        chk("lit_illegal_ignored", register_inp_flag, 0);
        tick();
        enter = 1'b1; cell_in = 4'd0; value_in = 3'd2;
        tick();
        enter = 1'b0;
        chk("lit_write_flag", register_inp_flag, 1);
        chk("lit_write_cell", reg_choose, 0);
        chk("lit_write_val", value_inp, 2);
        tick();

        // Submit gating and a winning check
        submit = 1'b1;
        tick();
        submit = 1'b0;
        chk("lit_submit_ignored", dp_check, 0);
        fill_free();
        submit = 1'b1; solved = 1'b1;
        tick();
        submit = 1'b0;
        chk("lit_check_1", dp_check, 1);
        tick();
        chk("lit_check_2", dp_check, 1);
        tick();
        chk("lit_judge", dp_check, 0);
        tick();
        chk("lit_won", won, 1);

        // Three failed checks lose the game
        start_game(2'b11);
        fill_free();
        for (int k = 0; k < 3; k++) begin
            submit_run(1'b0);
            if (k < 2) begin
                chk("lit_try_again", try_again_flag, 1);
                tick();
            end else begin
                chk("lit_lost", lost, 1);
            end
        end
        start_game(2'b11);
        fill_free();
        submit_run(1'b0);
        chk("lit_tries_cleared", try_again_flag, 1);
        tick();

        // Simultaneous enter and submit on a full board
        enter = 1'b1; submit = 1'b1; value_in = 3'd1;
        cell_in = 4'd0;
        for (int c = 15; c >= 0; c--) if (!m_fill[c]) cell_in = 4'(c);
        tick();
        enter = 1'b0; submit = 1'b0;
        chk("lit_enter_wins", state, 5);
        chk("lit_no_check", dp_check, 0);
        tick();

        // Asynchronous reset while checking
        submit = 1'b1; solved = 1'b0;
        tick();
        submit = 1'b0;
        #2;
        restart_n = 1'b0;
        #1;
        chk("lit_async_state", state, 0);
        chk("lit_async_check", dp_check, 0);
        model_reset();
        tick();
        restart_n = 1'b1;

        // Randomized play
        for (int n = 0; n < 4000; n++) begin
            if (m_st == 0 || m_st >= 9) start = ($urandom_range(0, 9) == 0);
            else start = ($urandom_range(0, 399) == 0);
            diff_sel = 2'($urandom_range(0, 3));
            enter = ($urandom_range(0, 2) == 0);
            submit = ($urandom_range(0, 3) == 0);
            solved = ($urandom_range(0, 2) == 0);
            value_in = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                                 : 3'($urandom_range(4, 7));
            cell_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                for (int c = 0; c < 16; c++) begin
                    int cc = (int'(cell_in) + c) % 16;
                    if (!(m_fill[cc] | m_user[cc])) begin
                        cell_in = 4'(cc);
                        break;
                    end
                end
            end
            if (enter && submit && !m_enter_legal()) submit = 1'b0;
            restart_n = ($urandom_range(0, 1499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
